// File: rtl/cla_seq_adder_ctrl_pkg.sv
// ============================================================================
// Module      : cla_pkg
// Description : Shared types and constants for the sequential CLA adder.
//               SLICE_W is the width of the one shared adder slice, the
//               cla_state_t enum is the controller state, and cla_idx_w()
//               sizes the nibble-step counter.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package cla_pkg;

  localparam int unsigned SLICE_W = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } cla_state_t;

  // Width of a counter that indexes nslice nibbles; never narrower than 1 bit.
  function automatic int unsigned cla_idx_w(input int unsigned nslice);
    return (nslice > 1) ? $clog2(nslice) : 1;
  endfunction

endpackage

`default_nettype wire

// File: rtl/cla_seq_adder_ctrl_if.sv
// ============================================================================
// Module      : cla_seq_adder_ctrl_if
// Description : Operand / result handshake bundle of the sequential adder.
//               in_valid/in_ready accept a, b, cin; out_valid/out_ready hand
//               back sum, cout. busy mirrors "operation in flight".
//               Optional macro CLA_SEQ_SUB_EN adds sub (request side) and ovf
//               (result side).
// Ports       : master = requester/consumer side, slave = adder side.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface cla_seq_adder_ctrl_if #(
  parameter int WIDTH = 16
);

  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             cin;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] sum;
  logic             cout;
  logic             busy;
`ifdef CLA_SEQ_SUB_EN
  logic             sub;
  logic             ovf;
`endif

  modport master (
    output in_valid, a, b, cin, out_ready,
`ifdef CLA_SEQ_SUB_EN
    output sub,
    input  ovf,
`endif
    input  in_ready, out_valid, sum, cout, busy
  );

  modport slave (
    input  in_valid, a, b, cin, out_ready,
`ifdef CLA_SEQ_SUB_EN
    input  sub,
    output ovf,
`endif
    output in_ready, out_valid, sum, cout, busy
  );

endinterface

`default_nettype wire

// File: rtl/cla_seq_adder_ctrl_cla4_slice.sv
// ============================================================================
// Module      : cla4_slice
// Description : Combinational 4-bit carry-lookahead adder in generate /
//               propagate form. All internal carries are flattened sums of
//               products of G, P and ci, so no carry ripples through the slice.
// Ports       : a_i[3:0], b_i[3:0], ci_i  -> s_o[3:0], co_o
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module cla4_slice (
  input  logic [3:0] a_i,
  input  logic [3:0] b_i,
  input  logic       ci_i,
  output logic [3:0] s_o,
  output logic       co_o
);

  logic [3:0] g_w;
  logic [3:0] p_w;
  logic [3:0] c_w;   // c_w[k] = carry into bit k

  assign g_w = a_i & b_i;
  assign p_w = a_i ^ b_i;

  assign c_w[0] = ci_i;
  assign c_w[1] = g_w[0] | (p_w[0] & ci_i);
  assign c_w[2] = g_w[1] | (p_w[1] & g_w[0]) | (p_w[1] & p_w[0] & ci_i);
  assign c_w[3] = g_w[2] | (p_w[2] & g_w[1]) | (p_w[2] & p_w[1] & g_w[0])
                | (p_w[2] & p_w[1] & p_w[0] & ci_i);

  assign co_o = g_w[3] | (p_w[3] & g_w[2]) | (p_w[3] & p_w[2] & g_w[1])
              | (p_w[3] & p_w[2] & p_w[1] & g_w[0])
              | (p_w[3] & p_w[2] & p_w[1] & p_w[0] & ci_i);

  assign s_o = p_w ^ c_w;

endmodule

`default_nettype wire

// File: rtl/cla_seq_adder_ctrl.sv
// ============================================================================
// Module      : cla_seq_adder_ctrl
// Description : Adds two WIDTH-bit operands by stepping one shared 4-bit CLA
//               slice across them, least-significant nibble first, one nibble
//               per clock. A registered carry links consecutive nibbles.
//               Accept in IDLE -> NSLICE cycles in RUN -> result held in DONE
//               until the consumer takes it.
// Ports       : clk, rst (sync, active high)
//               bus (slave modport): in_valid/in_ready/a/b/cin,
//               out_valid/out_ready/sum/cout, busy
// Config      : CLA_SEQ_SUB_EN - adds sub/ovf; sub=1 computes a - b.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module cla_seq_adder_ctrl
  import cla_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic                clk,
  input  logic                rst,
  cla_seq_adder_ctrl_if.slave bus
);

  localparam int unsigned NSLICE = WIDTH / SLICE_W;
  localparam int unsigned IDX_W  = cla_idx_w(NSLICE);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NSLICE - 1);

  if ((WIDTH % SLICE_W) != 0 || WIDTH < 8) begin : g_bad_width
    $error("cla_seq_adder_ctrl: WIDTH must be a multiple of 4 and >= 8");
  end

  cla_state_t       state_q, state_d;
  logic [IDX_W-1:0] idx_q,   idx_d;
  logic [WIDTH-1:0] a_q,     a_d;
  logic [WIDTH-1:0] b_q,     b_d;     // already inverted for subtraction
  logic             carry_q, carry_d;
  logic [WIDTH-1:0] sum_q,   sum_d;
  logic             cout_q,  cout_d;
`ifdef CLA_SEQ_SUB_EN
  logic             ovf_q,   ovf_d;
  logic             c_msb_w;          // carry into the top bit of the nibble
`endif

  // Bit offset of the current nibble; {idx,2'b00} == 4*idx for a 4-bit slice.
  logic [IDX_W+1:0] base_w;
  logic [3:0]       slc_a_w;
  logic [3:0]       slc_b_w;
  logic [3:0]       slc_s_w;
  logic             slc_co_w;

  assign base_w  = {idx_q, 2'b00};
  assign slc_a_w = a_q[base_w +: SLICE_W];
  assign slc_b_w = b_q[base_w +: SLICE_W];

  cla4_slice u_slice (
    .a_i  (slc_a_w),
    .b_i  (slc_b_w),
    .ci_i (carry_q),
    .s_o  (slc_s_w),
    .co_o (slc_co_w)
  );

`ifdef CLA_SEQ_SUB_EN
  // s3 = a3 ^ b3 ^ c3, so the carry into bit 3 falls out of the slice result.
  assign c_msb_w = slc_a_w[3] ^ slc_b_w[3] ^ slc_s_w[3];
`endif

  // --------------------------------------------------------------------------
  // Next-state and datapath
  // --------------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    a_d     = a_q;
    b_d     = b_q;
    carry_d = carry_q;
    sum_d   = sum_q;
    cout_d  = cout_q;
`ifdef CLA_SEQ_SUB_EN
    ovf_d   = ovf_q;
`endif

    case (state_q)
      IDLE: begin
        if (bus.in_valid) begin
          state_d = RUN;
          idx_d   = '0;
          a_d     = bus.a;
`ifdef CLA_SEQ_SUB_EN
          // a - b == a + ~b + 1; cin is ignored when subtracting.
          b_d     = bus.sub ? ~bus.b : bus.b;
          carry_d = bus.sub ? 1'b1   : bus.cin;
`else
          b_d     = bus.b;
          carry_d = bus.cin;
`endif
        end
      end

      RUN: begin
        sum_d[base_w +: SLICE_W] = slc_s_w;
        carry_d = slc_co_w;
        if (idx_q == LAST_IDX) begin
          state_d = DONE;
          idx_d   = '0;
          cout_d  = slc_co_w;
`ifdef CLA_SEQ_SUB_EN
          ovf_d   = c_msb_w ^ slc_co_w;
`endif
        end else begin
          idx_d = idx_q + IDX_W'(1);
        end
      end

      DONE: begin
        if (bus.out_ready) begin
          state_d = IDLE;
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // --------------------------------------------------------------------------
  // State registers
  // --------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      idx_q   <= '0;
      a_q     <= '0;
      b_q     <= '0;
      carry_q <= 1'b0;
      sum_q   <= '0;
      cout_q  <= 1'b0;
`ifdef CLA_SEQ_SUB_EN
      ovf_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      a_q     <= a_d;
      b_q     <= b_d;
      carry_q <= carry_d;
      sum_q   <= sum_d;
      cout_q  <= cout_d;
`ifdef CLA_SEQ_SUB_EN
      ovf_q   <= ovf_d;
`endif
    end
  end

  // --------------------------------------------------------------------------
  // Outputs
  // --------------------------------------------------------------------------
  assign bus.in_ready  = (state_q == IDLE);
  assign bus.out_valid = (state_q == DONE);
  assign bus.busy      = (state_q != IDLE);
  assign bus.sum       = sum_q;
  assign bus.cout      = cout_q;
`ifdef CLA_SEQ_SUB_EN
  assign bus.ovf       = ovf_q;
`endif

endmodule

`default_nettype wire

// File: tb/tb_cla_seq_adder_ctrl.sv
// ============================================================================
// Module      : tb_cla_seq_adder_ctrl
// Description : Directed self-checking bench for cla_seq_adder_ctrl (WIDTH=16).
//               Each scenario task drives its own vectors and compares the
//               DUT outputs with hand-computed values. Inputs are driven and
//               outputs sampled 1 time unit after the rising edge.
//               With CLA_SEQ_SUB_EN defined, the subtract scenario also runs.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

module tb_cla_seq_adder_ctrl;

  localparam int WIDTH = 16;

  logic clk;
  logic rst;
  int   n_checks;
  int   n_fail;

  cla_seq_adder_ctrl_if #(.WIDTH(WIDTH)) bus ();

  cla_seq_adder_ctrl #(.WIDTH(WIDTH)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Wait (bounded) for in_ready, then present one operand set for exactly the
  // accept edge. Returns after that edge.
  task automatic start_op(input logic [15:0] av, input logic [15:0] bv,
                          input logic ci);
    int n;
    n = 0;
    while (bus.in_ready !== 1'b1 && n < 20) begin
      tick();
      n++;
    end
    n_checks++;
    if (bus.in_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL start_op_timeout: in_ready=%b required 1", bus.in_ready);
    end
    bus.in_valid = 1'b1;
    bus.a        = av;
    bus.b        = bv;
    bus.cin      = ci;
    tick();
    bus.in_valid = 1'b0;
    bus.a        = 16'hDEAD;   // operands may change after accept
    bus.b        = 16'hBEEF;
    bus.cin      = 1'b1;
  endtask

  // Count edges until out_valid is seen, bounded.
  task automatic wait_out(output int lat);
    lat = 0;
    while (bus.out_valid !== 1'b1 && lat < 20) begin
      tick();
      lat++;
    end
    n_checks++;
    if (bus.out_valid !== 1'b1) begin
      n_fail++;
      $display("FAIL wait_out_timeout: out_valid=%b required 1", bus.out_valid);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    n_checks++;
    if ({bus.in_ready, bus.out_valid, bus.busy, bus.cout, bus.sum} !== {1'b1, 1'b0, 1'b0, 1'b0, 16'h0000}) begin
      n_fail++;
      $display("FAIL reset_state: rdy=%b vld=%b busy=%b cout=%b sum=%h required 1 0 0 0 0000",
               bus.in_ready, bus.out_valid, bus.busy, bus.cout, bus.sum);
    end
    // Abort an operation mid-RUN: nibble 0 (0x5) has already been written.
    start_op(16'h1234, 16'h4321, 1'b0);
    tick();
    n_checks++;
    if (bus.busy !== 1'b1 || bus.in_ready !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_pre_busy: busy=%b rdy=%b required 1 0", bus.busy, bus.in_ready);
    end
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    n_checks++;
    if ({bus.in_ready, bus.out_valid, bus.busy, bus.cout, bus.sum} !== {1'b1, 1'b0, 1'b0, 1'b0, 16'h0000}) begin
      n_fail++;
      $display("FAIL reset_mid_run: rdy=%b vld=%b busy=%b cout=%b sum=%h required 1 0 0 0 0000",
               bus.in_ready, bus.out_valid, bus.busy, bus.cout, bus.sum);
    end
  endtask

  task automatic test_basic_add();
    int lat;
    start_op(16'h1234, 16'h4321, 1'b0);
    // Right after the accept edge the block is busy and not yet valid.
    n_checks++;
    if (bus.out_valid !== 1'b0 || bus.busy !== 1'b1 || bus.in_ready !== 1'b0) begin
      n_fail++;
      $display("FAIL basic_after_accept: vld=%b busy=%b rdy=%b required 0 1 0",
               bus.out_valid, bus.busy, bus.in_ready);
    end
    wait_out(lat);
    // Four RUN edges after the accept edge; out_valid is up in the 5th cycle.
    n_checks++;
    if (lat !== 4) begin
      n_fail++;
      $display("FAIL basic_latency: edges=%0d required 4", lat);
    end
    n_checks++;
    if (bus.sum !== 16'h5555 || bus.cout !== 1'b0) begin
      n_fail++;
      $display("FAIL basic_sum: sum=%h cout=%b required 5555 0", bus.sum, bus.cout);
    end
    bus.out_ready = 1'b1;
    tick();
    bus.out_ready = 1'b0;
    n_checks++;
    if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL basic_release: rdy=%b vld=%b required 1 0", bus.in_ready, bus.out_valid);
    end
  endtask

  task automatic test_ripple();
    int lat;
    start_op(16'hFFFF, 16'h0000, 1'b1);
    wait_out(lat);
    n_checks++;
    if (bus.sum !== 16'h0000 || bus.cout !== 1'b1) begin
      n_fail++;
      $display("FAIL ripple_sum: sum=%h cout=%b required 0000 1", bus.sum, bus.cout);
    end
    bus.out_ready = 1'b1;
    tick();
    bus.out_ready = 1'b0;
  endtask

  task automatic test_backpressure();
    int lat;
    int bad;
    // F00F + 1FF1 = 0x11000: carry generated in nibble 0 and propagated up.
    start_op(16'hF00F, 16'h1FF1, 1'b0);
    wait_out(lat);
    bad = 0;
    for (int i = 0; i < 10; i++) begin
      bus.in_valid = i[0];
      bus.a        = 16'h0101 * i[15:0];
      bus.b        = 16'h1111;
      tick();
      if (bus.sum !== 16'h1000 || bus.cout !== 1'b1 || bus.out_valid !== 1'b1 ||
          bus.in_ready !== 1'b0) bad++;
    end
    bus.in_valid = 1'b0;
    n_checks++;
    if (bad != 0) begin
      n_fail++;
      $display("FAIL backpressure_hold: %0d unstable cycles, last sum=%h cout=%b vld=%b rdy=%b required 0, 1000 1 1 0",
               bad, bus.sum, bus.cout, bus.out_valid, bus.in_ready);
    end
    bus.out_ready = 1'b1;
    tick();
    bus.out_ready = 1'b0;
    n_checks++;
    if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0 || bus.busy !== 1'b0) begin
      n_fail++;
      $display("FAIL backpressure_release: rdy=%b vld=%b busy=%b required 1 0 0",
               bus.in_ready, bus.out_valid, bus.busy);
    end
    n_checks++;
    if (bus.sum !== 16'h1000 || bus.cout !== 1'b1) begin
      n_fail++;
      $display("FAIL backpressure_idle_hold: sum=%h cout=%b required 1000 1", bus.sum, bus.cout);
    end
  endtask

  task automatic test_back_to_back();
    logic [15:0] va [3];
    logic [15:0] vb [3];
    logic        vc [3];
    logic [15:0] es [3];
    logic        ec [3];
    int          acc_cyc [3];
    int          nacc;
    int          nres;
    int          cyc;
    logic        acc;
    va[0] = 16'hA5A5; vb[0] = 16'h5A5A; vc[0] = 1'b1; es[0] = 16'h0000; ec[0] = 1'b1;
    va[1] = 16'h1357; vb[1] = 16'h2468; vc[1] = 1'b1; es[1] = 16'h37C0; ec[1] = 1'b0;
    va[2] = 16'hC3C3; vb[2] = 16'h8421; vc[2] = 1'b0; es[2] = 16'h47E4; ec[2] = 1'b1;
    nacc = 0;
    nres = 0;
    cyc  = 0;
    bus.out_ready = 1'b1;
    bus.in_valid  = 1'b1;
    bus.a = va[0]; bus.b = vb[0]; bus.cin = vc[0];
    while (nres < 3 && cyc < 60) begin
      acc = bus.in_valid & bus.in_ready;
      if (bus.out_valid === 1'b1) begin
        n_checks++;
        if (bus.sum !== es[nres] || bus.cout !== ec[nres]) begin
          n_fail++;
          $display("FAIL b2b_result%0d: sum=%h cout=%b required %h %b",
                   nres, bus.sum, bus.cout, es[nres], ec[nres]);
        end
        nres++;
      end
      tick();
      cyc++;
      if (acc) begin
        acc_cyc[nacc] = cyc;
        nacc++;
        if (nacc < 3) begin
          bus.a = va[nacc]; bus.b = vb[nacc]; bus.cin = vc[nacc];
        end else begin
          bus.in_valid = 1'b0;
        end
      end
    end
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b0;
    n_checks++;
    if (nres != 3 || nacc != 3) begin
      n_fail++;
      $display("FAIL b2b_count: results=%0d accepts=%0d required 3 3", nres, nacc);
    end else begin
      n_checks++;
      if (acc_cyc[1] - acc_cyc[0] != 6 || acc_cyc[2] - acc_cyc[1] != 6) begin
        n_fail++;
        $display("FAIL b2b_spacing: gaps=%0d,%0d required 6,6",
                 acc_cyc[1] - acc_cyc[0], acc_cyc[2] - acc_cyc[1]);
      end
    end
  endtask

`ifdef CLA_SEQ_SUB_EN
  task automatic test_sub();
    int lat;
    bus.sub = 1'b1;
    start_op(16'h8000, 16'h0001, 1'b0);
    bus.sub = 1'b0;
    wait_out(lat);
    n_checks++;
    if (bus.sum !== 16'h7FFF || bus.cout !== 1'b1 || bus.ovf !== 1'b1) begin
      n_fail++;
      $display("FAIL sub_overflow: sum=%h cout=%b ovf=%b required 7fff 1 1",
               bus.sum, bus.cout, bus.ovf);
    end
    bus.out_ready = 1'b1;
    tick();
    bus.out_ready = 1'b0;
    bus.sub = 1'b1;
    start_op(16'h0005, 16'h0005, 1'b0);
    bus.sub = 1'b0;
    wait_out(lat);
    n_checks++;
    if (bus.sum !== 16'h0000 || bus.cout !== 1'b1 || bus.ovf !== 1'b0) begin
      n_fail++;
      $display("FAIL sub_equal: sum=%h cout=%b ovf=%b required 0000 1 0",
               bus.sum, bus.cout, bus.ovf);
    end
    bus.out_ready = 1'b1;
    tick();
    bus.out_ready = 1'b0;
  endtask
`endif

  initial begin
    n_checks      = 0;
    n_fail        = 0;
    rst           = 1'b1;
    bus.in_valid  = 1'b0;
    bus.a         = '0;
    bus.b         = '0;
    bus.cin       = 1'b0;
    bus.out_ready = 1'b0;
`ifdef CLA_SEQ_SUB_EN
    bus.sub       = 1'b0;
`endif
    tick();
    test_reset();
    test_basic_add();
    test_ripple();
    test_backpressure();
    test_back_to_back();
`ifdef CLA_SEQ_SUB_EN
    test_sub();
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
